// File: rtl/key_repeat_if.sv
// key_repeat_if
//   Bundles the key-conditioning signals between the keyboard decoder side
//   and the key_repeat stage.
//
//   enable                         game running (low = everything idle)
//   left/right/down_held           held levels, auto-repeating keys
//   rotate/drop/hold_held          held levels, one-shot keys
//   key_left/right/down            registered one-cycle action pulses
//   key_rotate/drop/hold           registered one-cycle action pulses
//   key_drop_held                  registered copy of drop_held & enable
//
//   master: decoder / stimulus side, slave: key_repeat.
interface key_repeat_if;
  logic enable;
  logic left_held;
  logic right_held;
  logic down_held;
  logic rotate_held;
  logic drop_held;
  logic hold_held;

  logic key_left;
  logic key_right;
  logic key_down;
  logic key_rotate;
  logic key_drop;
  logic key_hold;
  logic key_drop_held;

  modport master (
    output enable, left_held, right_held, down_held,
           rotate_held, drop_held, hold_held,
    input  key_left, key_right, key_down, key_rotate,
           key_drop, key_hold, key_drop_held
  );

  modport slave (
    input  enable, left_held, right_held, down_held,
           rotate_held, drop_held, hold_held,
    output key_left, key_right, key_down, key_rotate,
           key_drop, key_hold, key_drop_held
  );
endinterface

// File: rtl/key_repeat.sv
// key_repeat
//   Turns held key levels into single-cycle action pulses for game_control.
//   Left/right share one horizontal FSM with delayed auto-repeat (DAS then
//   ARR), down repeats at a fixed rate from the first press, and rotate,
//   drop and hold fire once per press.
//
//   Parameters
//     DAS_CYCLES       initial left/right pulse to first repeat (>= 2)
//     ARR_CYCLES       spacing of left/right repeats (>= 1)
//     DOWN_ARR_CYCLES  spacing of down pulses (>= 1)
//   Ports
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     keys  key_repeat_if.slave: enable, *_held inputs, key_* pulse outputs
module key_repeat #(
  parameter int DAS_CYCLES      = 17_000_000,
  parameter int ARR_CYCLES      = 5_000_000,
  parameter int DOWN_ARR_CYCLES = 5_000_000
) (
  input logic         clk,
  input logic         rst,
  key_repeat_if.slave keys
);

  localparam int H_MAX    = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int H_CW_RAW = $clog2(H_MAX);
  localparam int H_CW     = (H_CW_RAW < 1) ? 1 : H_CW_RAW;
  localparam int D_CW_RAW = $clog2(DOWN_ARR_CYCLES);
  localparam int D_CW     = (D_CW_RAW < 1) ? 1 : D_CW_RAW;

  localparam logic [H_CW-1:0] DAS_LAST  = H_CW'(DAS_CYCLES - 1);
  localparam logic [H_CW-1:0] ARR_LAST  = H_CW'(ARR_CYCLES - 1);
  localparam logic [D_CW-1:0] DOWN_LAST = D_CW'(DOWN_ARR_CYCLES - 1);

  localparam logic [1:0] H_IDLE   = 2'd0;
  localparam logic [1:0] H_DELAY  = 2'd1;
  localparam logic [1:0] H_REPEAT = 2'd2;

  localparam logic D_IDLE   = 1'b0;
  localparam logic D_REPEAT = 1'b1;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  logic prev_left, prev_right, prev_down, prev_rotate, prev_drop, prev_hold;
  logic press_left, press_right, press_down, press_rotate, press_drop, press_hold;

  logic [1:0]      h_state;
  logic            dir;
  logic [H_CW-1:0] h_cnt;
  logic            dir_held;
  logic            other_held;

  logic            d_state;
  logic [D_CW-1:0] d_cnt;

  assign press_left   = keys.left_held   & ~prev_left;
  assign press_right  = keys.right_held  & ~prev_right;
  assign press_down   = keys.down_held   & ~prev_down;
  assign press_rotate = keys.rotate_held & ~prev_rotate;
  assign press_drop   = keys.drop_held   & ~prev_drop;
  assign press_hold   = keys.hold_held   & ~prev_hold;

  assign dir_held   = (dir == DIR_R) ? keys.right_held : keys.left_held;
  assign other_held = (dir == DIR_R) ? keys.left_held  : keys.right_held;

  // prev_* sit at 1 through reset and while disabled, so a key already down
  // when the game (re)starts must be released once before it counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_left   <= 1'b1;
      prev_right  <= 1'b1;
      prev_down   <= 1'b1;
      prev_rotate <= 1'b1;
      prev_drop   <= 1'b1;
      prev_hold   <= 1'b1;
    end else if (!keys.enable) begin
      prev_left   <= 1'b1;
      prev_right  <= 1'b1;
      prev_down   <= 1'b1;
      prev_rotate <= 1'b1;
      prev_drop   <= 1'b1;
      prev_hold   <= 1'b1;
    end else begin
      prev_left   <= keys.left_held;
      prev_right  <= keys.right_held;
      prev_down   <= keys.down_held;
      prev_rotate <= keys.rotate_held;
      prev_drop   <= keys.drop_held;
      prev_hold   <= keys.hold_held;
    end
  end

  // One-shot keys need no state beyond prev_*; prev_* forced high while
  // disabled already keeps these at 0, the enable term just makes it explicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys.key_rotate    <= 1'b0;
      keys.key_drop      <= 1'b0;
      keys.key_hold      <= 1'b0;
      keys.key_drop_held <= 1'b0;
    end else begin
      keys.key_rotate    <= keys.enable & press_rotate;
      keys.key_drop      <= keys.enable & press_drop;
      keys.key_hold      <= keys.enable & press_hold;
      keys.key_drop_held <= keys.enable & keys.drop_held;
    end
  end

  // Horizontal FSM. A fresh press always wins over the current direction;
  // releasing the active direction hands over to the other key (restarting
  // the DAS delay without a pulse) if it is still held. Pulses default low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_state        <= H_IDLE;
      dir            <= DIR_L;
      h_cnt          <= '0;
      keys.key_left  <= 1'b0;
      keys.key_right <= 1'b0;
    end else begin
      keys.key_left  <= 1'b0;
      keys.key_right <= 1'b0;
      if (!keys.enable) begin
        h_state <= H_IDLE;
        dir     <= DIR_L;
        h_cnt   <= '0;
      end else if (press_left && press_right) begin
        // Ambiguous input: ignore both until one is re-pressed.
        h_state <= H_IDLE;
        h_cnt   <= '0;
      end else if (press_left || press_right) begin
        keys.key_left  <= press_left;
        keys.key_right <= press_right;
        dir            <= press_right ? DIR_R : DIR_L;
        h_cnt          <= '0;
        h_state        <= H_DELAY;
      end else if (h_state == H_DELAY || h_state == H_REPEAT) begin
        if (!dir_held) begin
          h_cnt <= '0;
          if (other_held) begin
            dir     <= ~dir;
            h_state <= H_DELAY;
          end else begin
            h_state <= H_IDLE;
          end
        end else if (h_cnt == ((h_state == H_DELAY) ? DAS_LAST : ARR_LAST)) begin
          keys.key_left  <= (dir == DIR_L);
          keys.key_right <= (dir == DIR_R);
          h_cnt          <= '0;
          h_state        <= H_REPEAT;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end else begin
        h_state <= H_IDLE;
      end
    end
  end

  // Down key: pulse on press, then every DOWN_ARR_CYCLES while held.
  // A release seen on the edge a repeat would fire wins over that repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state       <= D_IDLE;
      d_cnt         <= '0;
      keys.key_down <= 1'b0;
    end else begin
      keys.key_down <= 1'b0;
      if (!keys.enable) begin
        d_state <= D_IDLE;
        d_cnt   <= '0;
      end else if (d_state == D_IDLE) begin
        if (press_down) begin
          keys.key_down <= 1'b1;
          d_cnt         <= '0;
          d_state       <= D_REPEAT;
        end
      end else if (!keys.down_held) begin
        d_state <= D_IDLE;
        d_cnt   <= '0;
      end else if (d_cnt == DOWN_LAST) begin
        keys.key_down <= 1'b1;
        d_cnt         <= '0;
      end else begin
        d_cnt <= d_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat
//   Self-checking bench for key_repeat with DAS=4, ARR=2, DOWN_ARR=3.
//   A reference model derives each expected pulse from the time elapsed since
//   the press (or direction hand-over) that started the current sequence,
//   and is compared against the DUT every cycle. Directed sequences pin the
//   expected pulse patterns with literal values, then random stimulus runs.
module tb_key_repeat;

  localparam int DAS  = 4;
  localparam int ARR  = 2;
  localparam int DARR = 3;

  logic clk = 1'b0;
  logic rst;

  key_repeat_if kif ();

  key_repeat #(
    .DAS_CYCLES      (DAS),
    .ARR_CYCLES      (ARR),
    .DOWN_ARR_CYCLES (DARR)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .keys (kif.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state. Bit order of 6-bit key vectors:
  // 0 left, 1 right, 2 down, 3 rotate, 4 drop, 5 hold.
  // Output vector adds bit 6 = key_drop_held.
  logic [5:0] m_prev;
  int         m_edge = 0;
  int         h_dir;
  int         h_anchor;
  int         d_anchor;
  bit         d_active;
  logic [6:0] exp_out = '0;

  int pat [7];
  int cnt [7];
  int pat_idx;

  function automatic logic [6:0] dut_out();
    return {kif.key_drop_held, kif.key_hold, kif.key_drop, kif.key_rotate,
            kif.key_down, kif.key_right, kif.key_left};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_prev   = '1;
    h_dir    = 0;
    d_active = 1'b0;
    exp_out  = '0;
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic modelStep();
    logic [5:0] held;
    logic [5:0] pr;
    bit         h_pressed;
    int         t;
    held = {kif.hold_held, kif.drop_held, kif.rotate_held,
            kif.down_held, kif.right_held, kif.left_held};
    m_edge++;
    exp_out   = '0;
    h_pressed = 1'b0;
    if (rst) begin
      modelReset();
    end else if (!kif.enable) begin
      m_prev   = '1;
      h_dir    = 0;
      d_active = 1'b0;
    end else begin
      pr = held & ~m_prev;
      if (pr[0] && pr[1]) begin
        h_dir = 0;
      end else if (pr[0] || pr[1]) begin
        h_dir     = pr[0] ? 1 : 2;
        h_anchor  = m_edge;
        h_pressed = 1'b1;
      end else if (h_dir != 0 && !held[h_dir-1]) begin
        if (held[2-h_dir]) begin
          h_dir    = 3 - h_dir;
          h_anchor = m_edge;
        end else begin
          h_dir = 0;
        end
      end
      if (h_dir != 0) begin
        t = m_edge - h_anchor;
        if ((t == 0 && h_pressed) || (t >= DAS && ((t - DAS) % ARR) == 0))
          exp_out[h_dir-1] = 1'b1;
      end
      if (pr[2]) begin
        d_active = 1'b1;
        d_anchor = m_edge;
      end else if (!held[2]) begin
        d_active = 1'b0;
      end
      if (d_active && ((m_edge - d_anchor) % DARR) == 0) exp_out[2] = 1'b1;
      exp_out[3] = pr[3];
      exp_out[4] = pr[4];
      exp_out[5] = pr[5];
      exp_out[6] = held[4];
      m_prev = held;
    end
  endtask

  task automatic clearPat();
    for (int k = 0; k < 7; k++) begin
      pat[k] = 0;
      cnt[k] = 0;
    end
    pat_idx = 0;
  endtask

  function automatic int cntSum();
    int s = 0;
    for (int k = 0; k < 7; k++) s += cnt[k];
    return s;
  endfunction

  // Drive one cycle of inputs at the falling edge, step the model on the
  // rising edge, then record which DUT outputs pulsed for pattern checks.
  task automatic applyStimulus(input bit r, input bit en, input logic [5:0] held);
    logic [6:0] o;
    @(negedge clk);
    rst             = r;
    if (r) modelReset();
    kif.enable      = en;
    kif.left_held   = held[0];
    kif.right_held  = held[1];
    kif.down_held   = held[2];
    kif.rotate_held = held[3];
    kif.drop_held   = held[4];
    kif.hold_held   = held[5];
    @(posedge clk);
    modelStep();
    #3;
    o = dut_out();
    for (int k = 0; k < 7; k++) begin
      if (o[k]) begin
        cnt[k]++;
        if (pat_idx < 31) pat[k] |= (1 << pat_idx);
      end
    end
    pat_idx++;
  endtask

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    checkOutput("outputs", int'(dut_out()), int'(exp_out));
    checkOutput("left_right_exclusive", int'(kif.key_left & kif.key_right), 0);
  end

  initial begin
    logic [5:0] h;
    bit         en;
    rst             = 1'b1;
    kif.enable      = 1'b0;
    kif.left_held   = 1'b0;
    kif.right_held  = 1'b0;
    kif.down_held   = 1'b0;
    kif.rotate_held = 1'b0;
    kif.drop_held   = 1'b0;
    kif.hold_held   = 1'b0;
    modelReset();
    clearPat();

    // Left held through reset release is ignored until re-pressed.
    repeat (3) applyStimulus(1'b1, 1'b1, 6'b000001);
    clearPat();
    repeat (6) applyStimulus(1'b0, 1'b1, 6'b000001);
    checkOutput("left_held_through_reset", pat[0], 0);
    applyStimulus(1'b0, 1'b1, 6'b000000);

    // Left 12 cycles: pulses at 0,4,6,8,10.
    clearPat();
    repeat (12) applyStimulus(1'b0, 1'b1, 6'b000001);
    repeat (4) applyStimulus(1'b0, 1'b1, 6'b000000);
    checkOutput("left_das_arr_pattern", pat[0], 1361);
    checkOutput("left_no_right", pat[1], 0);

    // Down 10 cycles: pulses at 0,3,6,9.
    clearPat();
    repeat (10) applyStimulus(1'b0, 1'b1, 6'b000100);
    repeat (3) applyStimulus(1'b0, 1'b1, 6'b000000);
    checkOutput("down_arr_pattern", pat[2], 585);

    // Rotate: long hold then re-press gives exactly two pulses.
    clearPat();
    repeat (20) applyStimulus(1'b0, 1'b1, 6'b001000);
    applyStimulus(1'b0, 1'b1, 6'b000000);
    repeat (3) applyStimulus(1'b0, 1'b1, 6'b001000);
    applyStimulus(1'b0, 1'b1, 6'b000000);
    checkOutput("rotate_pulse_count", cnt[3], 2);

    // Drop 6 cycles: one pulse, drop_held level for 6 cycles.
    clearPat();
    repeat (6) applyStimulus(1'b0, 1'b1, 6'b010000);
    repeat (2) applyStimulus(1'b0, 1'b1, 6'b000000);
    checkOutput("drop_pulse_count", cnt[4], 1);
    checkOutput("drop_held_pattern", pat[6], 63);

    // Left into REPEAT, then right pressed: right takes over at once.
    repeat (6) applyStimulus(1'b0, 1'b1, 6'b000001);
    clearPat();
    repeat (5) applyStimulus(1'b0, 1'b1, 6'b000011);
    checkOutput("right_override_pattern", pat[1], 17);
    checkOutput("right_override_no_left", pat[0], 0);

    // Right released with left held: left resumes after DAS, then ARR.
    clearPat();
    repeat (9) applyStimulus(1'b0, 1'b1, 6'b000001);
    checkOutput("left_handover_pattern", pat[0], 336);
    checkOutput("left_handover_no_right", pat[1], 0);

    // Simultaneous left+right press: nothing.
    applyStimulus(1'b0, 1'b1, 6'b000000);
    clearPat();
    repeat (6) applyStimulus(1'b0, 1'b1, 6'b000011);
    checkOutput("simultaneous_press", pat[0] | pat[1], 0);

    // Enable dropped mid-repeat, then raised with keys still held.
    applyStimulus(1'b0, 1'b1, 6'b000000);
    repeat (8) applyStimulus(1'b0, 1'b1, 6'b000101);
    clearPat();
    repeat (3) applyStimulus(1'b0, 1'b0, 6'b000101);
    checkOutput("enable_low_silent", cntSum(), 0);
    clearPat();
    repeat (8) applyStimulus(1'b0, 1'b1, 6'b000101);
    checkOutput("enable_rise_held_silent", cntSum(), 0);
    clearPat();
    applyStimulus(1'b0, 1'b1, 6'b000000);
    repeat (2) applyStimulus(1'b0, 1'b1, 6'b000101);
    checkOutput("repress_after_enable_left", pat[0], 2);
    checkOutput("repress_after_enable_down", pat[2], 2);

    // Reset mid-sequence, keys still held afterwards: silence.
    repeat (3) applyStimulus(1'b0, 1'b1, 6'b000101);
    repeat (2) applyStimulus(1'b1, 1'b1, 6'b000101);
    clearPat();
    repeat (6) applyStimulus(1'b0, 1'b1, 6'b000101);
    checkOutput("reset_mid_sequence_silent", cntSum(), 0);

    // Random traffic against the model.
    h  = '0;
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 6; k++)
        if ($urandom_range(0, 5) == 0) h[k] = ~h[k];
      if (en) begin
        if ($urandom_range(0, 149) == 0) en = 1'b0;
      end else begin
        if ($urandom_range(0, 7) == 0) en = 1'b1;
      end
      applyStimulus($urandom_range(0, 299) == 0, en, h);
    end
    applyStimulus(1'b0, 1'b1, 6'b000000);

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
